unit_dispatch_scheduler: RTL

- Sits between the host command interface and the UNIT_COUNT processing units.
- Buffers incoming unit commands in an in-order FIFO.
- Dispatches each command to its destination unit once that unit is free and the command's source unit has no result in flight.
- Tracks per-unit busy state from start/done handshakes and provides a flush/drain sequence for the whole array.

---
 rtl/unit_dispatch_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/unit_dispatch_scheduler.sv
// unit_dispatch_scheduler: in-order command FIFO in front of UNIT_COUNT
// processing units. The head command is dispatched once its destination
// unit is free and ready, and once its source unit (if it reads one) has no
// result in flight. Per-unit busy bits are tracked from start/done, and a
// flush empties the queue and then waits for the array to drain.
// Optional: `define WATCHDOG_EN builds per-unit timeout counters that
// force-clear a hung unit's busy bit and raise a sticky error flag.
module unit_dispatch_scheduler #(
  parameter int UNIT_COUNT = 4,
  parameter int UID_W      = 2,
  parameter int PAYLOAD_W  = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [UID_W-1:0]              cmd_dst,
  input  logic [UID_W-1:0]              cmd_src,
  input  logic                          cmd_src_en,
  input  logic [PAYLOAD_W-1:0]          cmd_payload,
  input  logic                          flush,
  input  logic [UNIT_COUNT-1:0]         unit_ready,
  input  logic [UNIT_COUNT-1:0]         unit_done,
  output logic [UNIT_COUNT-1:0]         unit_start,
  output logic [PAYLOAD_W-1:0]          unit_payload,
  output logic [UNIT_COUNT-1:0]         busy_mask,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          idle,
  output logic [UNIT_COUNT-1:0]         error
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_RUN, S_DRAIN} state_t;

  typedef struct packed {
    logic [UID_W-1:0]     dst;
    logic [UID_W-1:0]     src;
    logic                 src_en;
    logic [PAYLOAD_W-1:0] payload;
  } cmd_t;

  state_t                 state_q, state_d;
  cmd_t                   mem [FIFO_DEPTH];
  cmd_t                   cmd_in, head;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [UNIT_COUNT-1:0]  busy_q;
  logic [UNIT_COUNT-1:0]  err_q;
  logic [UNIT_COUNT-1:0]  start_q;
  logic [PAYLOAD_W-1:0]   payload_q;
  logic                   push, dispatch, flush_run;

  assign cmd_in    = '{dst: cmd_dst, src: cmd_src, src_en: cmd_src_en, payload: cmd_payload};
  assign head      = mem[rd_ptr];
  assign flush_run = flush && (state_q == S_RUN);

  // Ready is held low in the reset cycle itself, not just after it.
  assign cmd_ready = !rst && (state_q == S_RUN) && (fifo_count < CNT_W'(FIFO_DEPTH));
  // A flush in the same cycle discards the offered command.
  assign push      = cmd_valid && cmd_ready && !flush;

  // Head-only issue; decision uses registered busy so a same-cycle done
  // only frees the unit for the following cycle.
  assign dispatch = (state_q == S_RUN) && !flush && (fifo_count != '0)
                 && !busy_q[head.dst] && unit_ready[head.dst]
                 && !(head.src_en && busy_q[head.src] && (head.src != head.dst));

  // FIFO storage; no reset needed, occupancy is governed by the pointers.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= cmd_in;

  // FIFO pointers and occupancy; flush drops everything queued.
  always_ff @(posedge clk) begin
    if (rst || flush_run) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + 1'b1;
      if (dispatch) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(dispatch);
    end
  end

  // Per-unit busy tracking (and optional watchdog).
  for (genvar u = 0; u < UNIT_COUNT; u++) begin : g_unit
    logic set_u, busy_r, expire;
    assign set_u = dispatch && (head.dst == UID_W'(u));
`ifdef WATCHDOG_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] wd_cnt;
    logic             err_r;
    assign expire = busy_r && (wd_cnt == TMO_W'(TIMEOUT - 1));
    // Cycle counter restarts at dispatch; expiry latches a sticky error.
    always_ff @(posedge clk) begin
      if (rst) begin
        wd_cnt <= '0;
        err_r  <= 1'b0;
      end else begin
        if (set_u)       wd_cnt <= '0;
        else if (busy_r) wd_cnt <= wd_cnt + 1'b1;
        if (expire)      err_r  <= 1'b1;
      end
    end
    assign err_q[u] = err_r;
`else
    assign expire   = 1'b0;
    assign err_q[u] = 1'b0;
`endif
    // Set on dispatch, clear on done or watchdog expiry; done on an idle
    // unit is a no-op since the bit is already clear.
    always_ff @(posedge clk) begin
      if (rst)                       busy_r <= 1'b0;
      else if (set_u)                busy_r <= 1'b1;
      else if (unit_done[u] || expire) busy_r <= 1'b0;
    end
    assign busy_q[u] = busy_r;
  end

  // Registered start pulse and payload, one cycle after the decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q   <= '0;
      payload_q <= '0;
    end else begin
      start_q <= dispatch ? (UNIT_COUNT'(1) << head.dst) : '0;
      if (dispatch) payload_q <= head.payload;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  // FSM next state: flush enters drain, drain exits when no unit is busy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (flush) state_d = S_DRAIN;
      S_DRAIN: if (busy_q == '0) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  assign unit_start   = start_q;
  assign unit_payload = payload_q;
  assign busy_mask    = busy_q;
  assign error        = err_q;
  assign idle         = (fifo_count == '0) && (busy_q == '0) && (state_q == S_RUN);
endmodule
